// File: rtl/prbs7_checker.sv
// PRBS-7 (x^7 + x^6 + 1) serial checker: self-seeds, verifies, locks, counts errors.
// Optional macro PRBS_INV_EN adds a d_inv port that inverts d_in before use.
module prbs7_checker #(
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_RUN    = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_in,
  input  logic                 d_valid,
  input  logic                 clr_cnt,
`ifdef PRBS_INV_EN
  input  logic                 d_inv,
`endif
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] bit_count
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int WE_W  = $clog2(WINDOW + 1);
  localparam int RUN_W = 8;

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t               r_state, w_state_n;
  logic [6:0]           r_lfsr, w_lfsr_n;
  logic [2:0]           r_seed_cnt, w_seed_cnt_n;
  logic [RUN_W-1:0]     r_run_cnt, w_run_cnt_n;
  logic [WIN_W-1:0]     r_win_cnt, w_win_cnt_n;
  logic [WE_W-1:0]      r_win_err, w_win_err_n, w_win_err_inc;
  logic                 r_locked, r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count, r_bit_count;
  logic                 w_din, w_exp, w_err, w_cnt_en, w_err_en;

`ifdef PRBS_INV_EN
  assign w_din = d_in ^ d_inv;
`else
  assign w_din = d_in;
`endif

  assign w_exp = r_lfsr[6] ^ r_lfsr[5];
  assign w_err = w_din ^ w_exp;

  always_comb begin
    w_state_n     = r_state;
    w_lfsr_n      = r_lfsr;
    w_seed_cnt_n  = r_seed_cnt;
    w_run_cnt_n   = r_run_cnt;
    w_win_cnt_n   = r_win_cnt;
    w_win_err_n   = r_win_err;
    w_cnt_en      = 1'b0;
    w_err_en      = 1'b0;
    w_win_err_inc = r_win_err + WE_W'(w_err);
    if (d_valid) begin
      unique case (r_state)
        SEED: begin
          w_lfsr_n = {r_lfsr[5:0], w_din};
          if (r_seed_cnt == 3'd6) begin
            // An all-zero register would lock the generator; keep seeding.
            w_seed_cnt_n = '0;
            if (w_lfsr_n != 7'h00) begin
              w_state_n   = VERIFY;
              w_run_cnt_n = '0;
            end
          end else begin
            w_seed_cnt_n = r_seed_cnt + 3'd1;
          end
        end
        VERIFY: begin
          w_lfsr_n = {r_lfsr[5:0], w_exp};
          if (w_err) begin
            w_state_n    = SEED;
            w_seed_cnt_n = '0;
          end else begin
            w_run_cnt_n = r_run_cnt + RUN_W'(1);
            if (w_run_cnt_n == RUN_W'(LOCK_RUN)) begin
              w_state_n   = LOCKED;
              w_win_cnt_n = '0;
              w_win_err_n = '0;
            end
          end
        end
        LOCKED: begin
          w_lfsr_n    = {r_lfsr[5:0], w_exp};
          w_cnt_en    = 1'b1;
          w_err_en    = w_err;
          w_win_cnt_n = r_win_cnt + WIN_W'(1);
          // The wrapping bit's error belongs to the window it closes.
          if (w_err && (w_win_err_inc == WE_W'(LOSS_THRESH))) begin
            w_state_n    = SEED;
            w_seed_cnt_n = '0;
            w_win_err_n  = w_win_err_inc;
          end else if (r_win_cnt == WIN_W'(WINDOW - 1)) begin
            w_win_err_n = '0;
          end else begin
            w_win_err_n = w_win_err_inc;
          end
        end
        default: w_state_n = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEED;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr      <= 7'h00;
      r_seed_cnt  <= '0;
      r_run_cnt   <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else begin
      r_lfsr      <= w_lfsr_n;
      r_seed_cnt  <= w_seed_cnt_n;
      r_run_cnt   <= w_run_cnt_n;
      r_win_cnt   <= w_win_cnt_n;
      r_win_err   <= w_win_err_n;
      r_locked    <= (w_state_n == LOCKED);
      r_err_pulse <= w_err_en;
      if (clr_cnt) begin
        r_err_count <= '0;
        r_bit_count <= '0;
      end else begin
        if (w_cnt_en && (r_bit_count != '1)) r_bit_count <= r_bit_count + ERR_CNT_W'(1);
        if (w_err_en && (r_err_count != '1)) r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: table of stream phases plus hand-written corner sequences.
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        rst, d_in, d_valid, clr_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] g = 7'h7F;

  prbs7_checker dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nbits;
    bit flip_last;
    bit exp_locked;
    int exp_err;
    int exp_bit;
    bit exp_pulse;
  } vec_t;

  vec_t tbl[12];

  function automatic bit next_bit();
    bit b;
    b = g[6] ^ g[5];
    g = {g[5:0], b};
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive, take the edge, settle past it.
  task automatic send(input bit flip, input bit v, input bit clr);
    if (v) d_in = next_bit() ^ flip;
    else   d_in = 1'($urandom_range(0, 1));
    d_valid = v;
    clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; d_valid = 1'b1; d_in = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Phases of one continuous PRBS stream; flipped bit is the last of a phase.
    tbl[0]  = '{22,  1'b0, 1'b0, 0, 0,   1'b0};
    tbl[1]  = '{1,   1'b0, 1'b1, 0, 0,   1'b0};
    tbl[2]  = '{177, 1'b0, 1'b1, 0, 177, 1'b0};
    tbl[3]  = '{10,  1'b1, 1'b1, 1, 187, 1'b1};
    tbl[4]  = '{1,   1'b0, 1'b1, 1, 188, 1'b0};
    tbl[5]  = '{4,   1'b0, 1'b1, 1, 192, 1'b0};
    tbl[6]  = '{5,   1'b1, 1'b1, 2, 197, 1'b1};
    tbl[7]  = '{5,   1'b1, 1'b1, 3, 202, 1'b1};
    tbl[8]  = '{5,   1'b1, 1'b1, 4, 207, 1'b1};
    tbl[9]  = '{5,   1'b1, 1'b0, 5, 212, 1'b1};
    tbl[10] = '{22,  1'b0, 1'b0, 5, 212, 1'b0};
    tbl[11] = '{1,   1'b0, 1'b1, 5, 212, 1'b0};

    do_reset();
    chk("rst locked",    int'(locked),    0);
    chk("rst err_pulse", int'(err_pulse), 0);
    chk("rst err_count", int'(err_count), 0);
    chk("rst bit_count", int'(bit_count), 0);

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].nbits; k++)
        send(tbl[i].flip_last && (k == tbl[i].nbits - 1), 1'b1, 1'b0);
      chk($sformatf("vec%0d locked", i),    int'(locked),    int'(tbl[i].exp_locked));
      chk($sformatf("vec%0d err_count", i), int'(err_count), tbl[i].exp_err);
      chk($sformatf("vec%0d bit_count", i), int'(bit_count), tbl[i].exp_bit);
      chk($sformatf("vec%0d err_pulse", i), int'(err_pulse), int'(tbl[i].exp_pulse));
    end

    // d_valid alternating: lock needs 23 valid bits, garbage ignored on idle cycles.
    do_reset();
    for (int k = 0; k < 22; k++) begin
      send(1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b0, 1'b0);
    end
    chk("dv 44cyc locked", int'(locked), 0);
    send(1'b0, 1'b1, 1'b0);
    chk("dv 45cyc locked", int'(locked), 1);
    send(1'b0, 1'b0, 1'b0);
    chk("dv 46cyc locked", int'(locked), 1);
    chk("dv 46cyc bit_count", int'(bit_count), 0);
    send(1'b0, 1'b1, 1'b0);
    chk("dv valid bit_count", int'(bit_count), 1);
    send(1'b0, 1'b0, 1'b0);
    chk("dv idle bit_count", int'(bit_count), 1);
    chk("dv idle err_pulse", int'(err_pulse), 0);
    send(1'b1, 1'b1, 1'b0);
    chk("dv err err_count", int'(err_count), 1);
    chk("dv err err_pulse", int'(err_pulse), 1);
    send(1'b1, 1'b0, 1'b0);
    chk("dv idle2 err_pulse", int'(err_pulse), 0);
    chk("dv idle2 err_count", int'(err_count), 1);
    chk("dv idle2 bit_count", int'(bit_count), 2);

    // Seven zeros are an illegal seed; lock comes 23 bits into the real stream.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      d_in = 1'b0; d_valid = 1'b1; clr_cnt = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("zero%0d err_pulse", k), int'(err_pulse), 0);
    end
    for (int k = 0; k < 22; k++) begin
      send(1'b0, 1'b1, 1'b0);
      chk($sformatf("acq%0d err_pulse", k), int'(err_pulse), 0);
    end
    chk("zeros 22 locked", int'(locked), 0);
    send(1'b0, 1'b1, 1'b0);
    chk("zeros 23 locked", int'(locked), 1);

    // clr_cnt on an errored locked bit beats the increment.
    repeat (3) send(1'b0, 1'b1, 1'b0);
    chk("pre-clr bit_count", int'(bit_count), 3);
    send(1'b1, 1'b1, 1'b1);
    chk("clr err_count", int'(err_count), 0);
    chk("clr bit_count", int'(bit_count), 0);
    chk("clr locked",    int'(locked),    1);
    send(1'b0, 1'b1, 1'b0);
    chk("post-clr bit_count", int'(bit_count), 1);
    send(1'b1, 1'b1, 1'b0);
    chk("post-clr err_count", int'(err_count), 1);

    // rst mid-LOCKED overrides a valid errored bit.
    rst = 1'b1;
    send(1'b1, 1'b1, 1'b0);
    chk("midrst locked",    int'(locked),    0);
    chk("midrst err_pulse", int'(err_pulse), 0);
    chk("midrst err_count", int'(err_count), 0);
    chk("midrst bit_count", int'(bit_count), 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
